// File: rtl/input_conditioner_pkg.sv
// Shared defaults and helpers for the switch/key input conditioner.
package input_conditioner_pkg;

    localparam int N_SW_DEF      = 8;
    localparam int N_KEY_DEF     = 4;
    localparam int DB_CYCLES_DEF = 1000000;

    // Counter must be able to hold DB_CYCLES itself.
    function automatic int cnt_width(input int db_cycles);
        return (db_cycles < 1) ? 1 : $clog2(db_cycles + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Raw board inputs and conditioned outputs of the input conditioner.
interface input_conditioner_if #(
    parameter int N_SW  = 8,
    parameter int N_KEY = 4
);
    logic [N_SW-1:0]  sw_in;
    logic [N_KEY-1:0] key_n_in;
    logic [N_SW-1:0]  sw_stable;
    logic [N_KEY-1:0] key_down;
    logic [N_KEY-1:0] key_press;
    logic             sw_changed;

    modport master (
        output sw_in, key_n_in,
        input  sw_stable, key_down, key_press, sw_changed
    );

    modport slave (
        input  sw_in, key_n_in,
        output sw_stable, key_down, key_press, sw_changed
    );
endinterface

// File: rtl/input_conditioner_debounce_bit.sv
// One input bit: two-flop synchronizer, qualification counter and stable register.
module debounce_bit
    import input_conditioner_pkg::*;
#(
    parameter int   DB_CYCLES = DB_CYCLES_DEF,
    parameter logic RST_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic stable_o
);

    localparam int            CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count differing samples; the increment that would reach DB_CYCLES commits instead.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= RST_VAL;
            sync2_q  <= RST_VAL;
            stable_q <= RST_VAL;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces slide switches and push-buttons; produces registered levels,
// key-press pulses and a switch-change pulse.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int N_SW      = N_SW_DEF,
    parameter int N_KEY     = N_KEY_DEF,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input logic                CLOCK_50,
    input logic                reset,
    input_conditioner_if.slave io
);

    logic [N_SW-1:0]  sw_stb;
    logic [N_KEY-1:0] key_stb;

    logic [N_SW-1:0]  sw_stable_q,  sw_stable_d;
    logic [N_KEY-1:0] key_down_q,   key_down_d;
    logic [N_KEY-1:0] key_press_q,  key_press_d;
    logic             sw_changed_q, sw_changed_d;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .RST_VAL   (1'b0)
        ) u_db (
            .clk_i    (CLOCK_50),
            .rst_i    (reset),
            .raw_i    (io.sw_in[i]),
            .stable_o (sw_stb[i])
        );
    end

    // Keys are active-low, so their idle (released) level is 1.
    for (genvar i = 0; i < N_KEY; i++) begin : g_key
        debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .RST_VAL   (1'b1)
        ) u_db (
            .clk_i    (CLOCK_50),
            .rst_i    (reset),
            .raw_i    (io.key_n_in[i]),
            .stable_o (key_stb[i])
        );
    end

    always_comb begin
        sw_stable_d  = sw_stb;
        key_down_d   = ~key_stb;
        key_press_d  = key_down_d & ~key_down_q;
        sw_changed_d = |(sw_stable_d ^ sw_stable_q);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sw_stable_q  <= '0;
            key_down_q   <= '0;
            key_press_q  <= '0;
            sw_changed_q <= 1'b0;
        end else begin
            sw_stable_q  <= sw_stable_d;
            key_down_q   <= key_down_d;
            key_press_q  <= key_press_d;
            sw_changed_q <= sw_changed_d;
        end
    end

    assign io.sw_stable  = sw_stable_q;
    assign io.key_down   = key_down_q;
    assign io.key_press  = key_press_q;
    assign io.sw_changed = sw_changed_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DB_CYCLES=4: directed scenarios plus random
// toggling, checked each cycle against a sample-window reference model.
module tb_input_conditioner;

    localparam int NS = 8;
    localparam int NK = 4;
    localparam int DB = 4;
    localparam int NB = NS + NK;
    localparam logic [NB-1:0] RSTV = {{NK{1'b1}}, {NS{1'b0}}};

    logic clk = 1'b0;
    logic rst;

    input_conditioner_if #(.N_SW(NS), .N_KEY(NK)) io ();

    input_conditioner #(
        .N_SW      (NS),
        .N_KEY     (NK),
        .DB_CYCLES (DB)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .io       (io)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: a bit's stable level flips once the last DB samples
    // seen by the synchronizer output all disagree with it; the visible
    // outputs trail the stable levels by one register stage.
    logic [NB-1:0] hist[$];
    logic [NB-1:0] stab_m;
    logic [NS-1:0] m_sw_stable  = '0;
    logic [NK-1:0] m_key_down   = '0;
    logic [NK-1:0] m_key_press  = '0;
    logic          m_sw_changed = 1'b0;
    bit            model_valid  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            repeat (DB + 2) hist.push_back(RSTV);
            stab_m       = RSTV;
            m_sw_stable  = '0;
            m_key_down   = '0;
            m_key_press  = '0;
            m_sw_changed = 1'b0;
        end else begin
            hist.push_back({io.key_n_in, io.sw_in});
            if (hist.size() > DB + 3) void'(hist.pop_front());
            m_sw_changed = (stab_m[NS-1:0] != m_sw_stable);
            m_key_press  = ~stab_m[NB-1:NS] & ~m_key_down;
            m_sw_stable  = stab_m[NS-1:0];
            m_key_down   = ~stab_m[NB-1:NS];
            for (int b = 0; b < NB; b++) begin
                bit all_diff;
                all_diff = 1'b1;
                for (int k = 0; k < DB; k++)
                    if (hist[hist.size() - 3 - k][b] == stab_m[b]) all_diff = 1'b0;
                if (all_diff) stab_m[b] = ~stab_m[b];
            end
        end
        model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid)
            check("cycle_outputs",
                  32'({io.sw_stable, io.key_down, io.key_press, io.sw_changed}),
                  32'({m_sw_stable, m_key_down, m_key_press, m_sw_changed}));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        io.sw_in    = '0;
        io.key_n_in = '1;
        tick(5);
        check("reset_outs", 32'({io.sw_stable, io.key_down, io.key_press, io.sw_changed}), 32'd0);
        rst = 1'b0;
        tick(20);
        check("idle_outs", 32'({io.sw_stable, io.key_down, io.key_press, io.sw_changed}), 32'd0);

        // Switch 3 rises and holds: visible after the 7th edge counting the sampling one.
        io.sw_in[3] = 1'b1;
        tick(6);
        check("sw3_not_yet", 32'(io.sw_stable[3]), 32'd0);
        tick(1);
        check("sw3_set", 32'(io.sw_stable), 32'h08);
        check("sw3_changed_pulse", 32'(io.sw_changed), 32'd1);
        check("model_sw3_set", 32'({m_sw_stable, m_sw_changed}), 32'h11);
        tick(1);
        check("sw3_changed_single", 32'(io.sw_changed), 32'd0);
        tick(4);

        // Three-sample glitch on key 0 must never qualify.
        io.key_n_in[0] = 1'b0;
        tick(3);
        io.key_n_in[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("key0_glitch", 32'({io.key_down[0], io.key_press[0]}), 32'd0);
        end

        // Key 2 bounces, then holds pressed.
        io.key_n_in[2] = 1'b0; tick(1);
        io.key_n_in[2] = 1'b1; tick(1);
        io.key_n_in[2] = 1'b0; tick(1);
        io.key_n_in[2] = 1'b1; tick(1);
        io.key_n_in[2] = 1'b0;
        tick(6);
        check("key2_not_yet", 32'(io.key_down[2]), 32'd0);
        tick(1);
        check("key2_down", 32'(io.key_down), 32'h4);
        check("key2_press", 32'(io.key_press), 32'h4);
        check("model_key2_press", 32'({m_key_down, m_key_press}), 32'h44);
        tick(1);
        check("key2_press_single", 32'({io.key_down, io.key_press}), 32'h40);
        io.key_n_in[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("key2_release_no_pulse", 32'(io.key_press), 32'd0);
        end
        check("key2_released", 32'(io.key_down[2]), 32'd0);

        // Keys 1 and 3 fall together and must pulse together.
        io.key_n_in[1] = 1'b0;
        io.key_n_in[3] = 1'b0;
        tick(6);
        check("key13_not_yet", 32'(io.key_press), 32'd0);
        tick(1);
        check("key13_press", 32'(io.key_press), 32'hA);
        tick(1);
        check("key13_press_single", 32'(io.key_press), 32'd0);
        io.key_n_in = '1;
        tick(10);

        // Reset two cycles into qualifying switch 0 discards the partial count.
        io.sw_in[0] = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(3);
        check("sw_in_reset", 32'({io.sw_stable, io.sw_changed}), 32'd0);
        rst = 1'b0;
        tick(6);
        check("sw0_not_yet", 32'(io.sw_stable[0]), 32'd0);
        tick(1);
        check("sw0_after_reset", 32'(io.sw_stable[0]), 32'd1);
        check("sw_changed_after_reset", 32'(io.sw_changed), 32'd1);
        tick(1);
        check("sw_changed_after_reset_single", 32'(io.sw_changed), 32'd0);

        // Random toggling with occasional resets, checked by the per-cycle compare.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NS; b++)
                if ($urandom_range(7) == 0) io.sw_in[b] = ~io.sw_in[b];
            for (int b = 0; b < NK; b++)
                if ($urandom_range(7) == 0) io.key_n_in[b] = ~io.key_n_in[b];
            rst = ($urandom_range(399) == 0);
            tick(1);
        end
        rst = 1'b0;
        tick(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter N_SW, default 8: number of slide-switch inputs.
REQ-002 Parameter N_KEY, default 4: number of push-button inputs.
REQ-003 Parameter DB_CYCLES, default 1000000 (20 ms at 50 MHz): debounce qualification length in clocks; legal range is 1 or more.
REQ-004 CLOCK_50  input  1  system clock; all logic SHALL be on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sw_in  input  N_SW  raw asynchronous switch levels, active-high.
REQ-007 key_n_in  input  N_KEY  raw asynchronous push-buttons, active-low (0 = pressed).
REQ-008 sw_stable  output  N_SW  debounced switch levels; these feed the mode, BCD-digit and control PIO inputs of the processor system.
REQ-009 key_down  output  N_KEY  debounced key state, active-high (1 = pressed).
REQ-010 key_press  output  N_KEY  one-cycle pulse per debounced press.
REQ-011 sw_changed  output  1  one-cycle pulse when any sw_stable bit changes.

Function
REQ-012 Each input bit SHALL pass through a two-flop synchronizer before any other use.
REQ-013 Each bit SHALL have an independent debounce counter of width clog2(DB_CYCLES+1).
REQ-014 When the synchronized value equals that bit's stable value, its counter SHALL clear to 0.
REQ-015 When the synchronized value differs from the stable value, the counter SHALL increment.
REQ-016 When an increment would reach DB_CYCLES, the stable value SHALL take the synchronized value and the counter SHALL clear in the same cycle.
REQ-017 A differing level held constant at the pin SHALL appear on the stable output exactly DB_CYCLES+2 clocks after the first clock edge that samples it.
REQ-018 Any return to the stable level before qualification SHALL abort the change, with no output effect.
REQ-019 key_down[i] SHALL be the inverse of key i's stable value.
REQ-020 key_press[i] SHALL be high for exactly one cycle: the first cycle in which key_down[i] reads 1.
REQ-021 Key release SHALL produce no pulse.
REQ-022 sw_changed SHALL be high for exactly one cycle: the first cycle in which sw_stable differs from its previous value.
REQ-023 Multiple bits changing in the same cycle SHALL produce a single sw_changed cycle.
REQ-024 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-025 Bits SHALL be fully independent; simultaneous key presses SHALL each pulse in their own qualifying cycle, including the same cycle.

Reset
REQ-026 While reset is high:
- switch synchronizers and switch stable values SHALL load 0;
- key synchronizers and key stable values SHALL load 1 (released);
- all counters SHALL load 0;
- sw_stable, key_down, key_press and sw_changed SHALL be 0.
REQ-027 Reset asserted mid-qualification SHALL discard the partial count.
REQ-028 After reset deasserts:
- a key held through reset SHALL qualify normally after DB_CYCLES+2 clocks and produce one key_press pulse;
- a switch already high SHALL qualify likewise and produce one sw_changed pulse.

Structure
REQ-029 A shared package SHALL hold the N_SW, N_KEY and DB_CYCLES defaults and the counter-width constant function.
REQ-030 Sub-module debounce_bit SHALL contain the synchronizer, counter and stable register for one bit, with a reset-value parameter; it SHALL be instantiated N_SW+N_KEY times.
REQ-031 Edge/pulse generation SHALL reside in input_conditioner.

Verification (bench uses DB_CYCLES=4)
REQ-032 Reset held with key_n_in=4'b1111 and sw_in=0 -> all outputs 0; after release and 20 idle cycles, all outputs remain 0.
REQ-033 sw_in[3] rises and holds -> sw_stable[3]=1 exactly 6 cycles later; sw_changed high for that single cycle.
REQ-034 key_n_in[0] low for 3 cycles then high (glitch) -> key_down and key_press stay 0 throughout.
REQ-035 key_n_in[2] bounces 0,1,0,1 then holds 0 -> key_down[2]=1 six cycles after the final fall; key_press[2] is a single pulse; release produces no pulse.
REQ-036 key_n_in[1] and key_n_in[3] fall in the same cycle -> both key_press bits pulse in the same single cycle.
REQ-037 Reset asserted 2 cycles into qualification of sw_in[0] -> sw_stable[0] stays 0 during reset; sets 6 cycles after reset deasserts if the input is still held.
